// File: rtl/header_engine_pkg.sv
// Shared definitions for the header-engine match-ID serializer slice.
// The MATCH_ID_STATS_EN build option uses STAT_W and sat_inc.
package header_engine_pkg;

    localparam int BVSIZE_DEF = 256;
    localparam int STAT_W     = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/lowest_set_encoder.sv
// Combinational lowest-set-bit encoder with any-set and single-bit-set flags.
module lowest_set_encoder
    import header_engine_pkg::*;
#(
    parameter int BVSIZE = BVSIZE_DEF,
    parameter int ID_W   = id_width(BVSIZE)
) (
    input  logic [BVSIZE-1:0] vec,
    output logic [ID_W-1:0]   idx,
    output logic              any_set,
    output logic              single_set
);

    always_comb begin
        idx = '0;
        // Scan downwards so the lowest set bit is the final write.
        for (int unsigned i = BVSIZE; i > 0; i--) begin
            if (vec[i-1]) idx = ID_W'(i - 1);
        end
        any_set    = |vec;
        single_set = any_set && ((vec & (vec - BVSIZE'(1))) == '0);
    end

endmodule

// File: rtl/match_id_serializer.sv
// Serializes a rule-hit vector into matched rule IDs, lowest first, one beat per cycle.
// Define MATCH_ID_STATS_EN to add saturating vector/hit/no-match counters.
module match_id_serializer
    import header_engine_pkg::*;
#(
    parameter int BVSIZE = BVSIZE_DEF,
    parameter int ID_W   = id_width(BVSIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BVSIZE-1:0] vec_in,
    input  logic              vec_valid,
    output logic              vec_ready,
    output logic [ID_W-1:0]   id_out,
    output logic              id_valid,
    input  logic              id_ready,
    output logic              id_last,
    output logic              no_match
`ifdef MATCH_ID_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_vectors,
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_nomatch
`endif
);

    state_e              state_q, state_d;
    logic [BVSIZE-1:0]   work_q, work_d;
    logic                nomatch_q, nomatch_d;
    logic [ID_W-1:0]     low_idx;
    logic                any_set;
    logic                single_set;
    logic                vec_acc;
    logic                beat_acc;

    lowest_set_encoder #(
        .BVSIZE (BVSIZE),
        .ID_W   (ID_W)
    ) u_enc (
        .vec        (work_q),
        .idx        (low_idx),
        .any_set    (any_set),
        .single_set (single_set)
    );

    // work_q is zero whenever the block is idle, so id_out needs no gating.
    assign vec_ready = rst && (state_q == ST_IDLE);
    assign id_valid  = (state_q == ST_EMIT);
    assign id_out    = low_idx;
    assign id_last   = id_valid && (!any_set || single_set);
    assign no_match  = id_valid && nomatch_q;
    assign vec_acc   = (state_q == ST_IDLE) && vec_valid;
    assign beat_acc  = id_valid && id_ready;

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        nomatch_d = nomatch_q;
        case (state_q)
            ST_IDLE: begin
                if (vec_valid) begin
                    work_d    = vec_in;
                    nomatch_d = (vec_in == '0);
                    state_d   = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (id_ready) begin
                    work_d = work_q & (work_q - BVSIZE'(1));
                    if (id_last) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            work_q    <= '0;
            nomatch_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            nomatch_q <= nomatch_d;
        end
    end

`ifdef MATCH_ID_STATS_EN
    logic [STAT_W-1:0] stat_vectors_q, stat_vectors_d;
    logic [STAT_W-1:0] stat_hits_q, stat_hits_d;
    logic [STAT_W-1:0] stat_nomatch_q, stat_nomatch_d;

    always_comb begin
        stat_vectors_d = stat_vectors_q;
        stat_hits_d    = stat_hits_q;
        stat_nomatch_d = stat_nomatch_q;
        if (vec_acc) stat_vectors_d = sat_inc(stat_vectors_q);
        if (beat_acc) begin
            if (no_match) stat_nomatch_d = sat_inc(stat_nomatch_q);
            else          stat_hits_d    = sat_inc(stat_hits_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_vectors_q <= '0;
            stat_hits_q    <= '0;
            stat_nomatch_q <= '0;
        end else begin
            stat_vectors_q <= stat_vectors_d;
            stat_hits_q    <= stat_hits_d;
            stat_nomatch_q <= stat_nomatch_d;
        end
    end

    assign stat_vectors = stat_vectors_q;
    assign stat_hits    = stat_hits_q;
    assign stat_nomatch = stat_nomatch_q;
`else
    logic unused_acc;
    assign unused_acc = vec_acc ^ beat_acc;
`endif

endmodule
